// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - BHT branch predictor and ID-stage resolver; BRES_STATS_EN adds stat counters
module branch_resolver #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        if_predict_taken,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic        id_kill,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic        id_cmp_result,
    input  logic        id_predicted,
    output logic        redirect,
    output logic [31:0] redirect_pc
`ifdef BRES_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            bht [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] id_idx;
    logic                  fire;
    logic                  mis;
    logic [1:0]            cur;
    logic                  unused_if_bits;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign id_idx = id_pc[INDEX_BITS+1:2];
    assign unused_if_bits = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};

    // Lookup reads the registered table only, so a same-index update is not visible until next cycle
    assign if_predict_taken = bht[if_idx][1];

    assign fire = id_valid & ~id_stall & ~id_kill;
    assign mis  = fire & (id_cmp_result != id_predicted);

    assign redirect    = mis;
    assign redirect_pc = id_cmp_result ? id_target : id_pc + 32'd8;

    assign cur = bht[id_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (fire) begin
            if (id_cmp_result && cur != 2'b11) begin
                bht[id_idx] <= cur + 2'd1;
            end else if (!id_cmp_result && cur != 2'b00) begin
                bht[id_idx] <= cur - 2'd1;
            end
        end
    end

`ifdef BRES_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (fire && stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mis && stat_mispredicts != 32'hFFFF_FFFF) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch prediction-and-resolution unit that sits on the consumer side of the ID-stage comparator. It provides a taken/not-taken prediction for the instruction being fetched in IF. In ID, it takes the comparator's one-bit `result` for the branch and compares it with the prediction carried down the pipe. On a mismatch it drives a PC redirect and flush. It also trains a table of 2-bit saturating counters, indexed by PC.

## Interface
Parameters:
- `INDEX_BITS`, 6: log2 of the number of BHT entries. The index is `pc[INDEX_BITS+1:2]`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  PC of the instruction in IF.
- `if_predict_taken`  out  1  combinational; 1 when `bht[idx(if_pc)] >= 2'b10`.
- `id_valid`  in  1  a conditional branch occupies ID this cycle.
- `id_stall`  in  1  ID is stalled by hazard logic; the resolution is not consumed.
- `id_kill`  in  1  exception/eret flush from CP0; the branch in ID is discarded.
- `id_pc`  in  32  PC of the branch in ID.
- `id_target`  in  32  computed branch target.
- `id_cmp_result`  in  1  actual outcome from the comparator.
- `id_predicted`  in  1  prediction that was recorded for this branch in IF.
- `redirect`  out  1  combinational; 1 on a consumed misprediction.
- `redirect_pc`  out  32  correct fetch PC. Value is don't-care when `redirect` = 0.
- `stat_branches`  out  32  consumed-branch counter (present only with `BRES_STATS_EN`).
- `stat_mispredicts`  out  32  consumed-misprediction counter (present only with `BRES_STATS_EN`).

## Operation
- Consume condition: `fire = id_valid & ~id_stall & ~id_kill`.
- Misprediction: `mis = fire & (id_cmp_result != id_predicted)`.
- `redirect = mis`.
- `redirect_pc`:
  - `id_target` when `id_cmp_result` = 1.
  - `id_pc + 32'd8` when `id_cmp_result` = 0, i.e. the instruction after the delay slot. The add is 32-bit wraparound.
- BHT: `2^INDEX_BITS` 2-bit counters.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - On `fire`, `bht[idx(id_pc)]` increments if `id_cmp_result` = 1 and decrements otherwise.
  - Counters saturate at 11 and 00. They never wrap.
- No update when `fire` = 0. A stalled branch updates exactly once, in the cycle its stall drops, provided `id_kill` = 0.
- `id_kill` has priority over everything. It gives no redirect, no training, and no stat increment.
- Read during write: when `idx(if_pc) == idx(id_pc)` and `fire`, `if_predict_taken` reflects the pre-update counter. There is no bypass.
- Aliasing between PCs that share an index is permitted; no tags are kept.

## Timing
- Prediction and redirect are combinational: zero-cycle latency from their inputs.
- BHT update takes effect at the rising edge after `fire`. A lookup in the next cycle sees the new value.
- Reset:
  - On the edge where `reset` = 1, every BHT entry becomes 01, and stats (if present) become 0.
  - After reset, `if_predict_taken` = 0 for every PC.
  - `redirect` depends only on inputs, so it is 0 whenever `id_valid` = 0.
- Reset mid-operation: reset overrides a simultaneous `fire`. No counter is trained and no stat increments on that edge.
- Back-to-back branches to the same index on consecutive cycles each apply one step, so two taken branches move a counter from 01 to 11.

## Configuration
- `BRES_STATS_EN` defined:
  - `stat_branches` increments on every `fire`.
  - `stat_mispredicts` increments on every `mis`.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
- `BRES_STATS_EN` undefined: the stat ports and registers are absent. All other behaviour is identical.

## Test plan
- Reset, then `if_pc` = 0x3000, 0x3004, 0x30FC → `if_predict_taken` = 0 for all three.
- `fire` with `id_pc` = 0x3010, `id_cmp_result` = 1, `id_predicted` = 0, `id_target` = 0x3100 → `redirect` = 1, `redirect_pc` = 0x3100. Next cycle, `if_pc` = 0x3010 gives prediction 1.
- Same branch with `id_cmp_result` = 0, `id_predicted` = 1 → `redirect_pc` = 0x3018. Train taken ×3, then not-taken ×1 → counter goes 01→10→11→11→10, and the prediction stays 1.
- `id_valid` = 1, `id_stall` = 1 for 3 cycles on a mispredicted branch → `redirect` = 0 and no training while stalled. When the stall drops, exactly one redirect and one counter step occur.
- `id_kill` = 1 with a mispredicted branch → `redirect` = 0, BHT unchanged, and with `BRES_STATS_EN` both stats unchanged.
- With `BRES_STATS_EN`: 5 consumed branches, 2 of them mispredicted → `stat_branches` = 5, `stat_mispredicts` = 2. Assert `reset` in the same cycle as a 6th `fire` → both stats read 0 afterwards.
